// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and baud divider helper for the UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK
  } state_t;

  // Rounded clk cycles per oversample tick.
  function automatic int unsigned calc_div(input longint unsigned clk_freq,
                                           input longint unsigned baud,
                                           input longint unsigned os);
    longint unsigned den;
    den = baud * os;
    return int'((clk_freq + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: one-cycle tick every DIV clk cycles.
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned CW  = (DIV < 2) ? 1 : $clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("uart_os_tick: clock divider below 2");
  end

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Free-running divider counter 0..DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_cfg_receiver.sv
// Configurable oversampling UART receiver with parity, framing, break and overrun reporting.
module uart_cfg_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 rx_idle
);

  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned MID = OVERSAMPLE / 2;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_cfg_receiver: DATA_BITS out of range");
  end
  if (PARITY > PAR_ODD) begin : g_bad_par
    $error("uart_cfg_receiver: PARITY out of range");
  end
  if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_os
    $error("uart_cfg_receiver: OVERSAMPLE must be a power of 2, at least 8");
  end

  logic                 tick;
  logic                 sync1, sync2;
  logic                 rxs;
  state_t               state;
  logic [OW-1:0]        os_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 samp0, samp1;
  logic                 maj;
  logic                 decide;
  logic                 bit_end;
  logic                 brk_now;
  logic                 perr_now;

  uart_os_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous line, idle-high reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rxd;
      sync2 <= sync1;
    end
  end

  assign rxs = sync2;

  // Majority of the two stored mid-bit samples and the current one.
  always_comb begin
    maj      = (samp0 & samp1) | (samp0 & rxs) | (samp1 & rxs);
    decide   = tick && (os_cnt == OW'(MID + 1));
    bit_end  = tick && (os_cnt == OW'(OVERSAMPLE - 1));
    brk_now  = !maj && (shreg == '0) && !par_bit;
    perr_now = (PARITY != PAR_NONE) && ((^shreg ^ par_bit) != (PARITY == PAR_ODD));
  end

  // Receive FSM with output register and ready/valid handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rx_idle    <= 1'b1;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      samp0      <= 1'b0;
      samp1      <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (tick) begin
        if (state != ST_IDLE && state != ST_BRK) os_cnt <= os_cnt + 1'b1;
        if (os_cnt == OW'(MID - 1)) samp0 <= rxs;
        if (os_cnt == OW'(MID))     samp1 <= rxs;

        case (state)
          ST_IDLE: begin
            if (!rxs) begin
              state   <= ST_START;
              rx_idle <= 1'b0;
              os_cnt  <= '0;
              bit_cnt <= '0;
              par_bit <= 1'b0;
            end
          end
          ST_START: begin
            if (decide && maj) begin
              state   <= ST_IDLE;
              rx_idle <= 1'b1;
            end else if (bit_end) begin
              state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (bit_end) begin
              if (bit_cnt == 4'(DATA_BITS - 1)) begin
                bit_cnt <= '0;
                state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          ST_PARITY: begin
            if (decide)  par_bit <= maj;
            if (bit_end) state   <= ST_STOP;
          end
          ST_STOP: begin
            // Commit at mid-stop and leave immediately so the next start edge is caught.
            if (decide) begin
              if (!rx_valid || rx_ready) begin
                rx_data    <= shreg;
                parity_err <= perr_now;
                frame_err  <= !maj;
                break_det  <= brk_now;
                rx_valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state   <= brk_now ? ST_BRK : ST_IDLE;
              rx_idle <= !brk_now;
            end
          end
          ST_BRK: begin
            if (rxs) begin
              state   <= ST_IDLE;
              rx_idle <= 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            rx_idle <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cfg_receiver.sv
// Self-checking bench: an 8N1 receiver and an 8E1 receiver driven on separate lines.
module tb_uart_cfg_receiver;

  localparam int unsigned CLK_FREQ = 7372800;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned OS       = 16;
  localparam int          BIT_CLK  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       rxd_a = 1'b1, rdy_a = 1'b1;
  logic [7:0] rx_data_a;
  logic       rx_valid_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_idle_a;

  logic       rxd_b = 1'b1, rdy_b = 1'b1;
  logic [7:0] rx_data_b;
  logic       rx_valid_b, parity_err_b, frame_err_b, break_det_b, overrun_b, rx_idle_b;

  int tests_run = 0;
  int fails = 0;
  int ovr_a = 0;
  int ovr_b = 0;
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];

  always #5 clk = ~clk;

  uart_cfg_receiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
    .rx_ready(rdy_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
    .break_det(break_det_a), .overrun(overrun_a), .rx_idle(rx_idle_a)
  );

  uart_cfg_receiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
    .rx_ready(rdy_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
    .break_det(break_det_b), .overrun(overrun_b), .rx_idle(rx_idle_b)
  );

  // Record every accepted word {break, frame, parity, data} and count overrun cycles.
  always @(negedge clk) begin
    if (rx_valid_a && rdy_a) q_a.push_back({break_det_a, frame_err_a, parity_err_a, rx_data_a});
    if (rx_valid_b && rdy_b) q_b.push_back({break_det_b, frame_err_b, parity_err_b, rx_data_b});
    if (overrun_a) ovr_a++;
    if (overrun_b) ovr_b++;
  end

  // Reference: what a correct receiver reports for a frame built from these line bits.
  function automatic logic [10:0] exp_word(input logic [7:0] d, input bit haspar,
                                           input bit odd, input bit pbit, input bit stop);
    int  ones;
    bit  perr, ferr, brk;
    ones = $countones(d) + ((haspar && pbit) ? 1 : 0);
    perr = haspar && (odd ? (ones % 2 == 0) : (ones % 2 == 1));
    ferr = !stop;
    brk  = !stop && (d == 8'h00) && !(haspar && pbit);
    return {brk, ferr, perr, d};
  endfunction

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rxd_b = v; else rxd_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input bit haspar, input bit pbit,
                      input bit stop, input int gap);
    drive(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
    if (haspar) drive(sel, pbit, BIT_CLK);
    drive(sel, stop, BIT_CLK);
    if (gap > 0) drive(sel, 1'b1, gap);
  endtask

  task automatic get_word(input bit sel, output logic [10:0] w, output bit got);
    int i;
    got = 1'b0;
    w   = 'x;
    i   = 0;
    while (!got && i < 400) begin
      if (!sel && q_a.size() > 0) begin w = q_a.pop_front(); got = 1'b1; end
      else if (sel && q_b.size() > 0) begin w = q_b.pop_front(); got = 1'b1; end
      else begin @(negedge clk); i++; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rxd_a = 1'b1; rxd_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_idle_a} !== 14'h1) begin
      fails++;
      $display("FAIL reset_a: got %b want %b",
               {rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_idle_a}, 14'h1);
    end
    tests_run++;
    if ({rx_valid_b, rx_data_b, parity_err_b, frame_err_b, break_det_b, overrun_b, rx_idle_b} !== 14'h1) begin
      fails++;
      $display("FAIL reset_b: got %b want %b",
               {rx_valid_b, rx_data_b, parity_err_b, frame_err_b, break_det_b, overrun_b, rx_idle_b}, 14'h1);
    end
    rst_n = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic test_8n1;
    logic [10:0] w, e;
    bit got;
    send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, BIT_CLK);
    e = exp_word(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    get_word(1'b0, w, got);
    tests_run++;
    if (!got) begin fails++; $display("FAIL 8n1_a5: no word within timeout, want %h", e); end
    else if (w !== e) begin fails++; $display("FAIL 8n1_a5: got %h want %h", w, e); end
    tests_run++;
    if (rx_idle_a !== 1'b1 || q_a.size() != 0) begin
      fails++; $display("FAIL 8n1_after: idle %b extra %0d want idle 1 extra 0", rx_idle_a, q_a.size());
    end
  endtask

  task automatic test_parity;
    logic [10:0] w, e;
    bit got;
    for (int p = 1; p >= 0; p--) begin
      send(1'b1, 8'h03, 1'b1, p[0], 1'b1, BIT_CLK);
      e = exp_word(8'h03, 1'b1, 1'b0, p[0], 1'b1);
      get_word(1'b1, w, got);
      tests_run++;
      if (!got) begin fails++; $display("FAIL parity_03_p%0d: no word, want %h", p, e); end
      else if (w !== e) begin fails++; $display("FAIL parity_03_p%0d: got %h want %h", p, w, e); end
    end
  endtask

  task automatic test_frame_break;
    logic [10:0] w, e;
    bit got, ok;
    send(1'b0, 8'h7E, 1'b0, 1'b0, 1'b0, BIT_CLK);
    e = exp_word(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    get_word(1'b0, w, got);
    tests_run++;
    if (!got) begin fails++; $display("FAIL frame_7e: no word, want %h", e); end
    else if (w !== e) begin fails++; $display("FAIL frame_7e: got %h want %h", w, e); end
    repeat (BIT_CLK) @(negedge clk);
    send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b0, 1'b0, 300);
    e = exp_word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    get_word(1'b0, w, got);
    tests_run++;
    if (!got) begin fails++; $display("FAIL break_word: no word, want %h", e); end
    else if (w !== e) begin fails++; $display("FAIL break_word: got %h want %h", w, e); end
    tests_run++;
    if (rx_idle_a !== 1'b0) begin fails++; $display("FAIL break_hold_idle: got %b want 0", rx_idle_a); end
    rxd_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_idle_a === 1'b1) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin fails++; $display("FAIL break_release: rx_idle %b after 20 clk, want 1", rx_idle_a); end
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic test_glitch;
    int  n0;
    bit  ok;
    n0 = q_a.size();
    drive(1'b0, 1'b0, 20);
    rxd_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rx_idle_a === 1'b1) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin fails++; $display("FAIL glitch_idle: rx_idle %b after 40 clk, want 1", rx_idle_a); end
    repeat (2 * BIT_CLK) @(negedge clk);
    tests_run++;
    if (q_a.size() != n0 || rx_valid_a !== 1'b0) begin
      fails++; $display("FAIL glitch_output: words %0d valid %b want 0 and 0", q_a.size() - n0, rx_valid_a);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] w, e;
    bit got;
    int o0;
    @(posedge clk); #1 rdy_a = 1'b0;
    o0 = ovr_a;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 0);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, BIT_CLK);
    tests_run++;
    if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h11) begin
      fails++; $display("FAIL b2b_hold: valid %b data %h want 1 11", rx_valid_a, rx_data_a);
    end
    tests_run++;
    if (ovr_a - o0 != 1) begin fails++; $display("FAIL b2b_overrun: got %0d cycles want 1", ovr_a - o0); end
    @(posedge clk); #1 rdy_a = 1'b1;
    e = exp_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    get_word(1'b0, w, got);
    tests_run++;
    if (!got) begin fails++; $display("FAIL b2b_accept: no word, want %h", e); end
    else if (w !== e) begin fails++; $display("FAIL b2b_accept: got %h want %h", w, e); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (rx_valid_a !== 1'b0 || q_a.size() != 0) begin
      fails++; $display("FAIL b2b_clear: valid %b extra %0d want 0 0", rx_valid_a, q_a.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] w, e;
    bit got;
    int o0;
    logic [7:0] d;
    d  = 8'hC3;
    o0 = ovr_a;
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) drive(1'b0, d[i], BIT_CLK);
    drive(1'b0, d[3], BIT_CLK / 2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_idle_a} !== 14'h1) begin
      fails++;
      $display("FAIL reset_mid: got %b want %b",
               {rx_valid_a, rx_data_a, parity_err_a, frame_err_a, break_det_a, overrun_a, rx_idle_a}, 14'h1);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 10 * BIT_CLK);
    tests_run++;
    if (q_a.size() != 0 || ovr_a != o0) begin
      fails++; $display("FAIL reset_mid_quiet: words %0d overruns %0d want 0 0", q_a.size(), ovr_a - o0);
    end
    send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, BIT_CLK);
    e = exp_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    get_word(1'b0, w, got);
    tests_run++;
    if (!got) begin fails++; $display("FAIL reset_mid_5a: no word, want %h", e); end
    else if (w !== e) begin fails++; $display("FAIL reset_mid_5a: got %h want %h", w, e); end
  endtask

  task automatic test_random;
    logic [10:0] w, e;
    logic [7:0] d;
    bit got, pbit, stop;
    for (int n = 0; n < 6; n++) begin
      d    = 8'($urandom_range(0, 255));
      if (n == 5) d = 8'h00;
      stop = ($urandom_range(0, 3) != 0);
      send(1'b0, d, 1'b0, 1'b0, stop, 2 * BIT_CLK);
      e = exp_word(d, 1'b0, 1'b0, 1'b0, stop);
      get_word(1'b0, w, got);
      tests_run++;
      if (!got) begin fails++; $display("FAIL rand_a_%0d: no word, want %h", n, e); end
      else if (w !== e) begin fails++; $display("FAIL rand_a_%0d: got %h want %h", n, w, e); end
    end
    for (int n = 0; n < 6; n++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = $urandom_range(0, 1) != 0;
      stop = ($urandom_range(0, 4) != 0);
      send(1'b1, d, 1'b1, pbit, stop, 2 * BIT_CLK);
      e = exp_word(d, 1'b1, 1'b0, pbit, stop);
      get_word(1'b1, w, got);
      tests_run++;
      if (!got) begin fails++; $display("FAIL rand_b_%0d: no word, want %h", n, e); end
      else if (w !== e) begin fails++; $display("FAIL rand_b_%0d: got %h want %h", n, w, e); end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_frame_break;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/uart_cfg_receiver.md
UART_CFG_RECEIVER -- requirements
Module: uart_cfg_receiver

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200, SHALL be the line bit rate.
REQ-003 Parameter OVERSAMPLE, default 16, SHALL be the ticks per bit; power of 2, minimum 8.
REQ-004 Parameter DATA_BITS, default 8, SHALL be the data bits per frame; range 5..9.
REQ-005 Parameter PARITY, default 0, SHALL select the parity mode: 0 none, 1 even, 2 odd.
REQ-006 Port clk, input, 1, SHALL be the single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1, SHALL be the reset: synchronous, active-low.
REQ-008 Port rxd, input, 1, SHALL be the asynchronous serial line; idle high.
REQ-009 Port rx_data, output, DATA_BITS, SHALL carry the received word, LSB first on the line.
REQ-010 Port rx_valid, output, 1, SHALL indicate that rx_data and the flags are valid.
REQ-011 Port rx_ready, input, 1, SHALL indicate that the consumer accepts the word.
REQ-012 Port parity_err, output, 1, SHALL flag a parity mismatch; qualified by rx_valid.
REQ-013 Port frame_err, output, 1, SHALL flag a stop bit sampled low; qualified by rx_valid.
REQ-014 Port break_det, output, 1, SHALL flag a break frame; qualified by rx_valid.
REQ-015 Port overrun, output, 1, SHALL pulse for one cycle when a completed frame is dropped.
REQ-016 Port rx_idle, output, 1, SHALL be high while the FSM is in IDLE.

Function
REQ-017 Tick generator SHALL use DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)).
REQ-018 Tick generator SHALL count 0..DIV-1 and assert tick for one cycle at DIV-1.
REQ-019 Elaboration SHALL fail if DIV<2, DATA_BITS is out of range, PARITY>2 or OVERSAMPLE is invalid.
REQ-020 rxd SHALL pass through a 2-flop synchronizer, reset value 1; all decisions SHALL use the synchronized bit.
REQ-021 FSM states SHALL be IDLE, START, DATA, PARITY, STOP and BRK.
REQ-022 IDLE -> START SHALL occur on a tick with the synchronized bit 0; the oversample counter clears to 0.
REQ-023 Each bit SHALL last OVERSAMPLE ticks; the bit value SHALL be the majority of samples at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, decided at OVERSAMPLE/2+1.
REQ-024 START with a majority of 1 SHALL return to IDLE (glitch reject), with no output and no flags.
REQ-025 After START, DATA SHALL shift DATA_BITS bits LSB first; then PARITY if PARITY!=0, else STOP.
REQ-026 PARITY state: parity_err = (XOR of data and parity bit) != (PARITY==2).
REQ-027 STOP SHALL commit the frame at the mid-bit decision point and leave STOP the same cycle, giving half a bit of resync slack for back-to-back frames.
REQ-028 A stop majority of 0 SHALL set frame_err.
REQ-029 If the data, the parity bit (if any) and the stop bit are all 0, break_det and frame_err SHALL both be set, and the FSM SHALL go to BRK, not IDLE.
REQ-030 BRK -> IDLE SHALL occur on the first tick with the synchronized bit 1.
REQ-031 Commit with rx_valid=0, or with rx_valid&rx_ready in the same cycle: load rx_data and the flags, rx_valid=1.
REQ-032 Commit with rx_valid=1 and rx_ready=0: drop the new frame, keep the held word, pulse overrun for one cycle.
REQ-033 rx_valid SHALL clear on the cycle after rx_valid&rx_ready when no commit coincides; rx_data and the flags SHALL be stable while rx_valid=1.
REQ-034 Latency SHALL be: rx_valid rises at most 3 clk after the stop-bit decision tick.

Reset
REQ-035 On rst_n=0 at a clk edge, all outputs SHALL be 0 except rx_idle=1; the FSM SHALL be in IDLE, counters 0, synchronizer 11.
REQ-036 Reset mid-frame SHALL abandon the partial frame, with no rx_valid and no overrun.
REQ-037 Reset SHALL have priority over a coincident commit or handshake.

Structure
REQ-038 Package uart_pkg SHALL hold the parity-mode constants, the FSM state encoding and the DIV rounding function.
REQ-039 Sub-module uart_os_tick SHALL be the tick generator, with parameters CLK_FREQ, BAUD, OVERSAMPLE and outputs tick.
REQ-040 All remaining logic SHALL reside in uart_cfg_receiver.

Verification (bench parameters: CLK_FREQ=7372800, BAUD=115200, OVERSAMPLE=16, so DIV=4 and 64 clk per bit)
REQ-041 Scenario 1, 8N1: frame 0xA5 with rx_ready=1 -> one rx_valid pulse, rx_data=0xA5, all flags 0, rx_idle=1 afterwards.
REQ-042 Scenario 2, PARITY=1: data 0x03 with parity bit 1 -> rx_data=0x03, parity_err=1; the same data with parity bit 0 -> parity_err=0.
REQ-043 Scenario 3: 0x7E with stop bit 0 -> frame_err=1, break_det=0. An all-zero frame with rxd held low for 300 clk -> break_det=1, frame_err=1, rx_idle=0 until rxd rises.
REQ-044 Scenario 4: 20-clk low glitch on idle rxd -> no rx_valid, rx_idle returns to 1 within 40 clk.
REQ-045 Scenario 5: back-to-back 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, one overrun pulse; rx_ready=1 then clears rx_valid.
REQ-046 Scenario 6: rst_n low for 2 clk at data bit 3 -> outputs reset, no rx_valid; a following frame 0x5A is received correctly.
